// File: rtl/mux_channel_sequencer.sv
// mux_channel_sequencer
//   Control stage in front of a quad 2-to-1 mux. Holds two channel registers (A, B) and
//   generates the mux select S and disable E. Every select change is wrapped in GAP
//   blanking cycles (E=1), so the mux output never switches between channels while enabled.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous, active-high reset
//   din     load data for the channel registers
//   load_a  capture din into A on this edge
//   load_b  capture din into B on this edge
//   mode    00 show A, 01 show B, 10 alternate A/B every DWELL cycles, 11 off
//   A, B    channel registers (drive mux A/B)
//   S       mux select (0 = A, 1 = B)
//   E       mux disable (1 = output forced low)
//   swap    one-cycle pulse on the cycle S takes a new value
module mux_channel_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DWELL = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_a,
  input  logic             load_b,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             S,
  output logic             E,
  output logic             swap
);

  localparam int unsigned CntMax = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;

  localparam logic [CntW-1:0] GapLast   = CntW'(GAP - 1);
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);

  localparam logic [1:0] ModeA   = 2'b00;
  localparam logic [1:0] ModeB   = 2'b01;
  localparam logic [1:0] ModeAlt = 2'b10;
  localparam logic [1:0] ModeOff = 2'b11;

  typedef enum logic {StBlank, StShow} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             s_q, s_d;
  logic             e_q, e_d;
  logic             swap_q, swap_d;
  logic             mode_chg;

  always_comb begin
    a_d      = load_a ? din : a_q;
    b_d      = load_b ? din : b_q;
    mode_d   = mode;
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    mode_chg = (mode != mode_q);

    if (mode == ModeOff) begin
      // Off parks in BLANK with the counter cleared; S is left where it was.
      state_d = StBlank;
      cnt_d   = '0;
    end else if (mode_chg) begin
      // Any mode change (in either state) restarts a full gap; fixed modes retarget S
      // here, while the mux is already blanked.
      state_d = StBlank;
      cnt_d   = '0;
      if (mode == ModeA) begin
        s_d = 1'b0;
      end else if (mode == ModeB) begin
        s_d = 1'b1;
      end
    end else if (state_q == StBlank) begin
      if (cnt_q == GapLast) begin
        state_d = StShow;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end else if (mode == ModeAlt) begin
      if (cnt_q == DwellLast) begin
        state_d = StBlank;
        cnt_d   = '0;
        s_d     = ~s_q;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end else begin
      cnt_d = '0;
    end

    e_d    = (state_d == StBlank);
    swap_d = s_d ^ s_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBlank;
      cnt_q   <= '0;
      mode_q  <= ModeA;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= 1'b0;
      e_q     <= 1'b1;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      e_q     <= e_d;
      swap_q  <= swap_d;
    end
  end

  assign A    = a_q;
  assign B    = b_q;
  assign S    = s_q;
  assign E    = e_q;
  assign swap = swap_q;

endmodule

// File: tb/tb_mux_channel_sequencer.sv
// Bench for mux_channel_sequencer: a DWELL=4/GAP=1 instance driven from a vector table
// plus an alternate-mode loop, and a DWELL=1/GAP=3 instance checked in a separate loop.
module tb_mux_channel_sequencer;

  logic       clk;
  logic       rst;
  logic       rst6;
  logic [3:0] din;
  logic       load_a;
  logic       load_b;
  logic [1:0] mode;
  logic [1:0] mode6;
  logic [3:0] a_o, b_o, a6_o, b6_o;
  logic       s_o, e_o, swap_o, s6_o, e6_o, swap6_o;

  int n_cmp  = 0;
  int n_fail = 0;

  mux_channel_sequencer #(.WIDTH(4), .DWELL(4), .GAP(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .din    (din),
    .load_a (load_a),
    .load_b (load_b),
    .mode   (mode),
    .A      (a_o),
    .B      (b_o),
    .S      (s_o),
    .E      (e_o),
    .swap   (swap_o)
  );

  mux_channel_sequencer #(.WIDTH(4), .DWELL(1), .GAP(3)) dut6 (
    .clk    (clk),
    .rst    (rst6),
    .din    (din),
    .load_a (load_a),
    .load_b (load_b),
    .mode   (mode6),
    .A      (a6_o),
    .B      (b6_o),
    .S      (s6_o),
    .E      (e6_o),
    .swap   (swap6_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic       la;
    logic       lb;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic       e;
    logic       sw;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] d, input logic la, input logic lb,
                     input logic [1:0] m, input logic [3:0] a, input logic [3:0] b,
                     input logic s, input logic e, input logic sw);
    vec_t v;
    v.rst = r; v.din = d; v.la = la; v.lb = lb; v.mode = m;
    v.a = a; v.b = b; v.s = s; v.e = e; v.sw = sw;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst    = v.rst;
    din    = v.din;
    load_a = v.la;
    load_b = v.lb;
    mode   = v.mode;
    @(posedge clk);
    #1;
    check($sformatf("v%0d.A", idx), 32'(a_o), 32'(v.a));
    check($sformatf("v%0d.B", idx), 32'(b_o), 32'(v.b));
    check($sformatf("v%0d.S", idx), 32'(s_o), 32'(v.s));
    check($sformatf("v%0d.E", idx), 32'(e_o), 32'(v.e));
    check($sformatf("v%0d.swap", idx), 32'(swap_o), 32'(v.sw));
  endtask

  localparam logic [3:0] Da = 4'b1010;
  localparam logic [3:0] Db = 4'b0101;

  int split;

  initial begin
    rst = 1'b1; rst6 = 1'b1;
    din = '0; load_a = 1'b0; load_b = 1'b0;
    mode = 2'b10; mode6 = 2'b10;

    // Reset, then load A and B while alternate mode starts (mode change adds one blank).
    //  rst din  la lb mode   A   B   S E sw
    add(1, 4'h0, 0, 0, 2'b10, 0,  0,  0,1,0);
    add(1, 4'h0, 0, 0, 2'b10, 0,  0,  0,1,0);
    add(0, Da,   1, 0, 2'b10, Da, 0,  0,1,0);
    add(0, Db,   0, 1, 2'b10, Da, Db, 0,0,0);
    add(0, 4'h0, 0, 0, 2'b10, Da, Db, 0,0,0);
    add(0, 4'h0, 0, 0, 2'b10, Da, Db, 0,0,0);
    add(0, 4'h0, 0, 0, 2'b10, Da, Db, 0,0,0);
    split = tbl.size();
    // Leave alternate for 00 (S already 0, no swap), then 00 -> 01 mid-SHOW.
    add(0, 4'h0, 0, 0, 2'b00, Da, Db, 0,1,0);
    add(0, 4'h0, 0, 0, 2'b00, Da, Db, 0,0,0);
    add(0, 4'h0, 0, 0, 2'b00, Da, Db, 0,0,0);
    add(0, 4'h0, 0, 0, 2'b01, Da, Db, 1,1,1);
    add(0, 4'h0, 0, 0, 2'b01, Da, Db, 1,0,0);
    add(0, 4'h0, 0, 0, 2'b01, Da, Db, 1,0,0);
    // Off for 3 cycles holds S=1, then 00 retargets S=0 and runs one gap.
    add(0, 4'h0, 0, 0, 2'b11, Da, Db, 1,1,0);
    add(0, 4'h0, 0, 0, 2'b11, Da, Db, 1,1,0);
    add(0, 4'h0, 0, 0, 2'b11, Da, Db, 1,1,0);
    add(0, 4'h0, 0, 0, 2'b00, Da, Db, 0,1,1);
    add(0, 4'h0, 0, 0, 2'b00, Da, Db, 0,0,0);
    // Alternate again, reset mid-dwell with a pending load_a that must be dropped.
    add(0, 4'h0, 0, 0, 2'b10, Da, Db, 0,1,0);
    add(0, 4'h0, 0, 0, 2'b10, Da, Db, 0,0,0);
    add(0, 4'h0, 0, 0, 2'b10, Da, Db, 0,0,0);
    add(1, 4'hF, 1, 0, 2'b10, 0,  0,  0,1,0);
    add(0, 4'h0, 0, 0, 2'b10, 0,  0,  0,1,0);
    add(0, 4'h0, 0, 0, 2'b10, 0,  0,  0,0,0);
    add(0, 4'hF, 1, 0, 2'b10, 4'hF, 0, 0,0,0);
    add(0, 4'h3, 1, 1, 2'b10, 4'h3, 4'h3, 0,0,0);
    add(0, 4'h0, 0, 0, 2'b10, 4'h3, 4'h3, 0,0,0);
    add(0, 4'h0, 0, 0, 2'b10, 4'h3, 4'h3, 1,1,1);

    for (int i = 0; i < split; i++) apply(tbl[i], i);

    // Alternate run: E pattern 1,0,0,0,0 with S flipping and swap pulsing on each blank.
    for (int i = 0; i < 20; i++) begin
      logic exp_e, exp_s;
      rst = 1'b0; load_a = 1'b0; load_b = 1'b0; mode = 2'b10;
      @(posedge clk);
      #1;
      exp_e = (i % 5) == 0;
      exp_s = ((i / 5) % 2) == 0;
      check($sformatf("alt%0d.E", i), 32'(e_o), 32'(exp_e));
      check($sformatf("alt%0d.S", i), 32'(s_o), 32'(exp_s));
      check($sformatf("alt%0d.swap", i), 32'(swap_o), 32'(exp_e));
    end

    for (int i = split; i < tbl.size(); i++) apply(tbl[i], i);

    // GAP=3, DWELL=1: after the initial blank (mode change from reset value plus a gap),
    // E is low on exactly one cycle in four and S only moves while blanked.
    rst = 1'b0; load_a = 1'b0; load_b = 1'b0; mode = 2'b00;
    rst6 = 1'b0; mode6 = 2'b10;
    for (int k = 1; k <= 24; k++) begin
      logic exp_e, exp_s, exp_sw;
      int j;
      @(posedge clk);
      #1;
      if (k < 4) begin
        exp_e = 1'b1; exp_s = 1'b0; exp_sw = 1'b0;
      end else begin
        j      = k - 4;
        exp_e  = (j % 4) != 0;
        exp_s  = (((j + 3) / 4) % 2) == 1;
        exp_sw = (j % 4) == 1;
      end
      check($sformatf("g3_%0d.E", k), 32'(e6_o), 32'(exp_e));
      check($sformatf("g3_%0d.S", k), 32'(s6_o), 32'(exp_s));
      check($sformatf("g3_%0d.swap", k), 32'(swap6_o), 32'(exp_sw));
    end
    check("g3.A", 32'(a6_o), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
